uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver paired with the existing transmitter; recovers 8N1 frames from the serial line.
- Runs on the same 16x-baud clock, bclk.
- Delivers a byte plus a one-cycle done strobe to the command parser feeding the DDS registers.
- Flags framing errors.

Parameters:
- DATA_BITS, 8, number of data bits per frame, sent LSB first.
- OVERSAMPLE, 16, bclk cycles per bit; must be a power of two and at least 8.

Ports:
- bclk  in  1  16x-baud clock; all logic is on its rising edge.
- rst  in  1  asynchronous active-low reset.
- RX  in  1  serial line, asynchronous, idle high.
- rx_dout  out  DATA_BITS  last correctly received byte.
- rx_done  out  1  one-bclk pulse; rx_dout is valid from this cycle on.
- frame_err  out  1  one-bclk pulse on a bad stop bit.
- rx_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Interface (already decided): one clock, bclk; reset rst is asynchronous and active-low.
- Reset values: rx_dout=0, rx_done=0, frame_err=0, rx_busy=0, state=IDLE, synchronizer flops=1.
- Synchronizer: RX passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s only.
- Counter: cnt is log2(OVERSAMPLE) bits wide. It increments every cycle outside IDLE and wraps from OVERSAMPLE-1 to 0.
- Bit sampling: take a 3-sample majority of rx_s at cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is decided at cnt = OVERSAMPLE/2+1.
- IDLE: on rx_s==0, go to START. That cycle counts as cnt=0 of the start bit.
- START: at the decision point, if majority=1, treat it as a false start and return to IDLE with no outputs. If majority=0, continue; at the cnt wrap go to DATA with bit index 0.
- DATA: at each decision point, shift the majority value in at the MSB of the shift register (LSB-first line order). At the cnt wrap, increment the bit index; after DATA_BITS bits, go to STOP.
- STOP, decision point, majority=1: load rx_dout from the shift register, pulse rx_done, go to IDLE. This early exit gives a back-to-back margin of half a bit.
- STOP, decision point, majority=0: pulse frame_err, leave rx_dout unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break condition therefore produces exactly one frame_err.
- Latency (default parameters): start detect at cycle 0; stop decision at cycle 9*16+9=153; rx_done/frame_err are high in cycle 154. rx_done is never asserted in the same cycle as frame_err.
- Back-to-back frames: a start edge arriving at any point after returning to IDLE is accepted, including in the very next cycle.
- Reset mid-frame: abort immediately, clear all outputs, discard the partial byte.
- rx_dout holds its value until the next good frame.
- There is no back-pressure; the consumer must take rx_dout within one frame time.

Decomposition:
- Shared package uart_pkg holds: OVERSAMPLE, DATA_BITS, the state encoding (IDLE, START, DATA, STOP, WAIT_HIGH), and the sample-point constants derived from OVERSAMPLE. The existing transmitter is migrated to the same constants.
- One sub-module, uart_rx_sync: the 2-flop synchronizer plus the 3-tap majority filter, which outputs rx_s and the voted bit.
- The FSM, counters and shift register stay in uart_rx.

Test Plan:
- Byte 0x55: reset, then a 16-bclk/bit frame of 0x55 → rx_done for 1 cycle at start+154, rx_dout=0x55, frame_err never asserted.
- Back-to-back bytes: 0xA3 then 0x0F with zero idle between frames → two rx_done pulses 160 cycles apart, rx_dout=0xA3 then 0x0F.
- Glitch rejection: RX low for 4 bclk, then high → rx_busy pulses, returns to IDLE, no rx_done, no frame_err, rx_dout unchanged.
- Framing error: 0x00 frame with stop=0, held low 40 more bclk then high → exactly one frame_err, rx_dout keeps its previous value 0x0F, the next 0x3C frame is received correctly.
- Mid-frame reset and noise: assert rst during data bit 4 → all outputs 0 immediately; after release, a 0xFF frame is received correctly. Flipping a single sample (cnt=7) of each bit of a 0x96 frame still yields rx_dout=0x96.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and sample-point helpers
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  // Majority taps sit around mid-bit; the bit is decided on the last tap.
  function automatic int sample_first(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int sample_mid(input int os);
    return os / 2;
  endfunction

  function automatic int sample_last(input int os);
    return os / 2 + 1;
  endfunction

  localparam int SAMPLE_FIRST = sample_first(OVERSAMPLE);
  localparam int SAMPLE_MID   = sample_mid(OVERSAMPLE);
  localparam int SAMPLE_LAST  = sample_last(OVERSAMPLE);

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop RX synchronizer plus 3-tap majority vote over consecutive rx_s samples
module uart_rx_sync (
  input  logic bclk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic vote
);

  logic s1, s2, h0, h1;

  // Flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      h0 <= 1'b1;
      h1 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      h0 <= s2;
      h1 <= h0;
    end
  end

  assign rx_s = s2;
  assign vote = (s2 & h0) | (s2 & h1) | (h0 & h1);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver on the 16x-baud clock with done strobe and framing-error flag
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = uart_pkg::DATA_BITS,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                 bclk,
  input  logic                 rst,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(sample_last(OVERSAMPLE));
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);

  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, idx_n;
  logic [DATA_BITS-1:0] shreg, sh_n, dout_n;
  logic                 done_n, err_n;
  logic                 rx_s, vote, decide, wrap;

  uart_rx_sync u_sync (
    .bclk (bclk),
    .rst  (rst),
    .rx   (RX),
    .rx_s (rx_s),
    .vote (vote)
  );

  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_dout   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= idx_n;
      shreg     <= sh_n;
      rx_dout   <= dout_n;
      rx_done   <= done_n;
      frame_err <= err_n;
    end
  end

  assign decide  = (cnt == CNT_DECIDE);
  assign wrap    = (cnt == CNT_LAST);
  assign rx_busy = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    idx_n   = bit_idx;
    sh_n    = shreg;
    dout_n  = rx_dout;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        // The detecting cycle is cnt=0 of the start bit, so the next one is 1.
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
          cnt_n   = CNT_W'(1);
        end
      end
      START: begin
        if (decide && vote) begin
          state_n = IDLE;
        end else if (wrap) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (decide) sh_n = {vote, shreg[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_idx == IDX_W'(DATA_BITS - 1)) state_n = STOP;
          else                                  idx_n   = bit_idx + IDX_W'(1);
        end
      end
      STOP: begin
        // Leaving at mid-stop gives half a bit of slack for back-to-back frames.
        if (decide) begin
          if (vote) begin
            dout_n  = shreg;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  logic       bclk = 1'b0;
  logic       rst;
  logic       RX;
  logic [7:0] rx_dout;
  logic       rx_done, frame_err, rx_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         done_cnt  = 0;
  int         err_cnt   = 0;
  int         both_cnt  = 0;
  int         wide_cnt  = 0;
  bit         busy_seen = 1'b0;
  logic       prev_done = 1'b0;
  int         done_cyc[$];
  logic [7:0] done_val[$];

  // Two sync flops plus the 154-cycle receiver latency, counted from the RX drive edge.
  localparam int LAT = 156;

  uart_rx dut (
    .bclk      (bclk),
    .rst       (rst),
    .RX        (RX),
    .rx_dout   (rx_dout),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 bclk = ~bclk;

  always @(posedge bclk) cyc <= cyc + 1;

  always @(negedge bclk) begin
    if (rx_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      done_val.push_back(rx_dout);
    end
    if (frame_err) err_cnt++;
    if (rx_done && frame_err) both_cnt++;
    if (rx_done && prev_done) wide_cnt++;
    prev_done = rx_done;
    if (rx_busy) busy_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge bclk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input bit noise,
                            output int start);
    logic v;
    start = cyc;
    for (int b = 0; b < 10; b++) begin
      v = (b == 0) ? 1'b0 : (b == 9) ? stop : data[b-1];
      for (int s = 0; s < 16; s++) begin
        RX = (noise && s == 7) ? ~v : v;
        @(negedge bclk);
      end
    end
  endtask

  function automatic logic [31:0] val_at(input int i);
    return (done_val.size() > i) ? 32'(done_val[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] cyc_at(input int i);
    return (done_cyc.size() > i) ? 32'(done_cyc[i]) : 32'hDEAD;
  endfunction

  initial begin
    int t0, t1, d0, e0;
    logic [9:0] fr;

    rst = 1'b0;
    RX  = 1'b1;
    repeat (3) @(negedge bclk);
    check_eq("rst_dout", rx_dout, 0);
    check_eq("rst_done", rx_done, 0);
    check_eq("rst_ferr", frame_err, 0);
    check_eq("rst_busy", rx_busy, 0);
    rst = 1'b1;
    idle(5);

    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b1, 1'b0, t0);
    idle(20);
    check_eq("b55_count", done_cnt - d0, 1);
    check_eq("b55_lat", cyc_at(d0) - t0, LAT);
    check_eq("b55_dout", rx_dout, 8'h55);
    check_eq("b55_ferr", err_cnt - e0, 0);

    d0 = done_cnt;
    send_frame(8'hA3, 1'b1, 1'b0, t0);
    send_frame(8'h0F, 1'b1, 1'b0, t1);
    idle(20);
    check_eq("b2b_count", done_cnt - d0, 2);
    check_eq("b2b_first", val_at(d0), 8'hA3);
    check_eq("b2b_second", val_at(d0 + 1), 8'h0F);
    check_eq("b2b_gap", cyc_at(d0 + 1) - cyc_at(d0), 160);
    check_eq("b2b_dout", rx_dout, 8'h0F);

    d0 = done_cnt; e0 = err_cnt;
    busy_seen = 1'b0;
    RX = 1'b0;
    repeat (4) @(negedge bclk);
    idle(20);
    check_eq("glitch_busy_seen", busy_seen, 1);
    check_eq("glitch_busy_now", rx_busy, 0);
    check_eq("glitch_done", done_cnt - d0, 0);
    check_eq("glitch_ferr", err_cnt - e0, 0);
    check_eq("glitch_dout", rx_dout, 8'h0F);

    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h00, 1'b0, 1'b0, t0);
    RX = 1'b0;
    repeat (40) @(negedge bclk);
    idle(10);
    check_eq("ferr_count", err_cnt - e0, 1);
    check_eq("ferr_done", done_cnt - d0, 0);
    check_eq("ferr_dout", rx_dout, 8'h0F);
    check_eq("ferr_busy", rx_busy, 0);
    d0 = done_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, t0);
    idle(20);
    check_eq("after_ferr_count", done_cnt - d0, 1);
    check_eq("after_ferr_dout", rx_dout, 8'h3C);

    fr = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 5 * 16 + 8; k++) begin
      RX = fr[k / 16];
      @(negedge bclk);
    end
    check_eq("midrst_busy_before", rx_busy, 1);
    rst = 1'b0;
    #1;
    check_eq("midrst_dout", rx_dout, 0);
    check_eq("midrst_done", rx_done, 0);
    check_eq("midrst_ferr", frame_err, 0);
    check_eq("midrst_busy", rx_busy, 0);
    RX = 1'b1;
    repeat (3) @(negedge bclk);
    rst = 1'b1;
    idle(5);
    d0 = done_cnt;
    send_frame(8'hFF, 1'b1, 1'b0, t0);
    idle(20);
    check_eq("post_rst_count", done_cnt - d0, 1);
    check_eq("post_rst_dout", rx_dout, 8'hFF);

    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h96, 1'b1, 1'b1, t0);
    idle(20);
    check_eq("noise_count", done_cnt - d0, 1);
    check_eq("noise_dout", rx_dout, 8'h96);
    check_eq("noise_ferr", err_cnt - e0, 0);

    check_eq("done_and_ferr", both_cnt, 0);
    check_eq("done_width", wide_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
